lsu_mem_responder: RTL and testbench

//  Load/store responder for the execute-stage memory controls (rd_en, wr_en, mem_type).

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 68 ++++++
 rtl/lsu_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_lsu_mem_responder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store responder: memory access types and FSM states.
package lsu_pkg;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b011;
    localparam logic [2:0] MT_HU = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store replication/strobes, access legality, load shift and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  mem_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic        is_store,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic        access_ok,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic        type_ok;
    logic        aligned;
    logic [31:0] shifted;

    always_comb begin
        st_wdata = wdata;
        st_wstrb = '0;
        type_ok  = 1'b0;
        aligned  = 1'b1;
        case (mem_type)
            MT_B: begin
                st_wdata = {4{wdata[7:0]}};
                st_wstrb = 4'b0001 << addr_lo;
                type_ok  = 1'b1;
            end
            MT_H: begin
                st_wdata = {2{wdata[15:0]}};
                st_wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                type_ok  = 1'b1;
                aligned  = ~addr_lo[0];
            end
            MT_W: begin
                st_wstrb = 4'b1111;
                type_ok  = 1'b1;
                aligned  = (addr_lo == 2'b00);
            end
            MT_BU: type_ok = ~is_store;
            MT_HU: begin
                type_ok = ~is_store;
                aligned = ~addr_lo[0];
            end
            default: type_ok = 1'b0;
        endcase
        if (!is_store) begin
            st_wstrb = '0;
        end
        access_ok = type_ok & aligned;
    end

    always_comb begin
        shifted = ld_word >> {ld_off, 3'b000};
        case (ld_type)
            MT_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            MT_BU:   ld_data = {24'd0, shifted[7:0]};
            MT_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            MT_HU:   ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_responder.sv
// Execute-stage load/store responder: one valid/ready bus transaction per access, with
// pipeline stall, load extension and error/timeout reporting.
module lsu_mem_responder
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [2:0]  mem_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_err_q, mem_err_d;
    logic        req_valid_q, req_valid_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  type_q, type_d;
    logic [1:0]  off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic        access_ok;
    logic [31:0] ld_data;
    logic        req_legal;
    logic [CW-1:0] cnt_inc;
    logic        timed_out;
    logic        stall_c;

    lsu_align u_align (
        .mem_type  (mem_type),
        .addr_lo   (addr[1:0]),
        .wdata     (wdata),
        .is_store  (wr_en),
        .st_wdata  (st_wdata),
        .st_wstrb  (st_wstrb),
        .access_ok (access_ok),
        .ld_type   (type_q),
        .ld_off    (off_q),
        .ld_word   (bus_rdata),
        .ld_data   (ld_data)
    );

    assign req_legal = (rd_en ^ wr_en) & access_ok;
    assign cnt_inc   = cnt_q + CW'(1);
    assign timed_out = (cnt_inc == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        mem_err_d   = 1'b0;
        req_valid_d = req_valid_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        type_d      = type_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        stall_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_en || wr_en) begin
                    if (req_legal) begin
                        stall_c     = 1'b1;
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        we_d        = wr_en;
                        addr_d      = {addr[31:2], 2'b00};
                        wdata_d     = st_wdata;
                        wstrb_d     = st_wstrb;
                        type_d      = mem_type;
                        off_d       = addr[1:0];
                        cnt_d       = '0;
                    end else begin
                        mem_err_d = 1'b1;
                        rdata_d   = '0;
                    end
                end
            end
            REQ, WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_inc;
                // timeout wins over a handshake or response landing in the same cycle
                if (timed_out) begin
                    state_d     = DONE;
                    req_valid_d = 1'b0;
                    rdata_d     = '0;
                    mem_err_d   = 1'b1;
                end else if (state_q == REQ) begin
                    if (bus_req_ready) begin
                        req_valid_d = 1'b0;
                        state_d     = WAIT;
                    end
                end else if (bus_rsp_valid) begin
                    if (!we_q) begin
                        rdata_d = ld_data;
                    end
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        stall = stall_c & rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rdata_q     <= '0;
            mem_err_q   <= 1'b0;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            type_q      <= '0;
            off_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            mem_err_q   <= mem_err_d;
            req_valid_q <= req_valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            type_q      <= type_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rdata         = rdata_q;
    assign mem_err       = mem_err_q;
    assign bus_req_valid = req_valid_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign bus_wstrb     = wstrb_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: stores, loads, illegal accesses, ready stalls, timeout, reset.
module tb_lsu_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  mem_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int tests;
    int fails;

    lsu_mem_responder #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_en         (rd_en),
        .wr_en         (wr_en),
        .mem_type      (mem_type),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .stall         (stall),
        .mem_err       (mem_err),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] strb);
        chk({tag, " valid"}, {31'd0, bus_req_valid}, 32'd1);
        chk({tag, " stall"}, {31'd0, stall}, 32'd1);
        chk({tag, " we"}, {31'd0, bus_we}, {31'd0, we});
        chk({tag, " addr"}, bus_addr, a);
        chk({tag, " wdata"}, bus_wdata, wd);
        chk({tag, " wstrb"}, {28'd0, bus_wstrb}, {28'd0, strb});
    endtask

    // One legal access: issue, hold ready low for nready cycles, respond in the first WAIT cycle.
    task automatic do_tx(input string tag, input logic rd, input logic wr, input logic [2:0] mt,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                         input int nready, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [3:0] e_strb, input logic chk_rd, input logic [31:0] e_rdata);
        rd_en = rd; wr_en = wr; mem_type = mt; addr = a; wdata = wd;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        #1;
        chk({tag, " stall idle"}, {31'd0, stall}, 32'd1);
        chk({tag, " valid idle"}, {31'd0, bus_req_valid}, 32'd0);
        next_cycle();
        rd_en = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < nready; i++) begin
            chk_req({tag, " hold"}, wr, e_addr, e_wdata, e_strb);
            next_cycle();
        end
        bus_req_ready = 1'b1;
        #1;
        chk_req({tag, " req"}, wr, e_addr, e_wdata, e_strb);
        next_cycle();
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = rword;
        #1;
        chk({tag, " wait valid"}, {31'd0, bus_req_valid}, 32'd0);
        chk({tag, " wait stall"}, {31'd0, stall}, 32'd1);
        next_cycle();
        bus_rsp_valid = 1'b0;
        chk({tag, " done stall"}, {31'd0, stall}, 32'd0);
        chk({tag, " done err"}, {31'd0, mem_err}, 32'd0);
        if (chk_rd) chk({tag, " rdata"}, rdata, e_rdata);
        next_cycle();
        chk({tag, " idle stall"}, {31'd0, stall}, 32'd0);
        if (chk_rd) chk({tag, " rdata hold"}, rdata, e_rdata);
    endtask

    task automatic do_illegal(input string tag, input logic rd, input logic wr,
                              input logic [2:0] mt, input logic [31:0] a);
        rd_en = rd; wr_en = wr; mem_type = mt; addr = a;
        #1;
        chk({tag, " stall"}, {31'd0, stall}, 32'd0);
        next_cycle();
        rd_en = 1'b0; wr_en = 1'b0;
        #1;
        chk({tag, " err"}, {31'd0, mem_err}, 32'd1);
        chk({tag, " rdata"}, rdata, 32'd0);
        chk({tag, " valid"}, {31'd0, bus_req_valid}, 32'd0);
        next_cycle();
        chk({tag, " err clear"}, {31'd0, mem_err}, 32'd0);
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0;
        rd_en = 1'b1; wr_en = 1'b0; mem_type = 3'b010; addr = 32'h0; wdata = 32'h0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
        next_cycle();
        next_cycle();
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst valid", {31'd0, bus_req_valid}, 32'd0);
        chk("rst err", {31'd0, mem_err}, 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst addr", bus_addr, 32'd0);
        chk("rst wstrb", {28'd0, bus_wstrb}, 32'd0);
        rd_en = 1'b0;
        rst_n = 1'b1;
        next_cycle();

        do_tx("SW",  1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0,
              32'h104, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0);
        do_tx("SB",  1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0,
              32'h200, 32'hA5A5A5A5, 4'b1000, 1'b0, 32'h0);
        do_tx("SH",  1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0,
              32'h200, 32'hABCDABCD, 4'b1100, 1'b0, 32'h0);
        do_tx("LB",  1'b1, 1'b0, 3'b000, 32'h301, 32'h0, 32'h00008000, 0,
              32'h300, 32'h0, 4'b0000, 1'b1, 32'hFFFFFF80);
        do_tx("LBU", 1'b1, 1'b0, 3'b011, 32'h301, 32'h0, 32'h00008000, 0,
              32'h300, 32'h0, 4'b0000, 1'b1, 32'h00000080);
        do_tx("LHU", 1'b1, 1'b0, 3'b100, 32'h302, 32'h0, 32'hBEEF0000, 0,
              32'h300, 32'h0, 4'b0000, 1'b1, 32'h0000BEEF);
        do_tx("LH",  1'b1, 1'b0, 3'b001, 32'h302, 32'h0, 32'h80010000, 0,
              32'h300, 32'h0, 4'b0000, 1'b1, 32'hFFFF8001);
        do_tx("LW slow", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 4,
              32'h100, 32'h0, 4'b0000, 1'b1, 32'hCAFEF00D);

        do_illegal("LW misaligned", 1'b1, 1'b0, 3'b010, 32'h102);
        do_illegal("rd&wr", 1'b1, 1'b1, 3'b010, 32'h100);
        do_illegal("SBU type", 1'b0, 1'b1, 3'b011, 32'h100);
        do_illegal("SH misaligned", 1'b0, 1'b1, 3'b001, 32'h101);

        // never-ready bus: 8 cycles in REQ, then DONE with the error pulse
        do_tx("LW pre-timeout", 1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h13572468, 0,
              32'h10C, 32'h0, 4'b0000, 1'b1, 32'h13572468);
        rd_en = 1'b1; mem_type = 3'b010; addr = 32'h100; bus_req_ready = 1'b0;
        #1;
        chk("TO stall idle", {31'd0, stall}, 32'd1);
        next_cycle();
        rd_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("TO valid", {31'd0, bus_req_valid}, 32'd1);
            chk("TO stall", {31'd0, stall}, 32'd1);
            chk("TO no err", {31'd0, mem_err}, 32'd0);
            next_cycle();
        end
        chk("TO done valid", {31'd0, bus_req_valid}, 32'd0);
        chk("TO done err", {31'd0, mem_err}, 32'd1);
        chk("TO done rdata", rdata, 32'd0);
        chk("TO done stall", {31'd0, stall}, 32'd0);
        next_cycle();
        chk("TO idle err", {31'd0, mem_err}, 32'd0);
        chk("TO idle valid", {31'd0, bus_req_valid}, 32'd0);

        // reset while in WAIT, then a stale response
        do_tx("LW pre-reset", 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h11223344, 0,
              32'h104, 32'h0, 4'b0000, 1'b1, 32'h11223344);
        rd_en = 1'b1; mem_type = 3'b010; addr = 32'h100; bus_req_ready = 1'b1;
        next_cycle();
        rd_en = 1'b0;
        next_cycle();
        bus_req_ready = 1'b0;
        chk("RST wait stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("RST stall", {31'd0, stall}, 32'd0);
        chk("RST valid", {31'd0, bus_req_valid}, 32'd0);
        chk("RST rdata", rdata, 32'd0);
        chk("RST addr", bus_addr, 32'd0);
        chk("RST err", {31'd0, mem_err}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        bus_rsp_valid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        next_cycle();
        bus_rsp_valid = 1'b0;
        chk("stale rdata", rdata, 32'd0);
        chk("stale stall", {31'd0, stall}, 32'd0);
        chk("stale valid", {31'd0, bus_req_valid}, 32'd0);
        do_tx("LW post-reset", 1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h55AA55AA, 0,
              32'h108, 32'h0, 4'b0000, 1'b1, 32'h55AA55AA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
